multu_seq_param: RTL and testbench

//  Parametrised iterative shift-add multiplier; successor to the fixed 32-bit multu.

---
 rtl/mult_pkg.sv | 19 +
 rtl/twos_negate.sv | 13 +
 rtl/multu_seq_param.sv | 136 +++++++++++++
 tb/tb_multu_seq_param.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential multiplier:
// FSM state encoding and a counter-width helper.
package mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/twos_negate.sv
// Conditional two's-complement negate, used for operand
// magnitude and for the final sign fix-up of the product.
module twos_negate #(
    parameter int N = 8
) (
    input  logic         cond,
    input  logic [N-1:0] x,
    output logic [N-1:0] y
);

    assign y = cond ? (~x + N'(1)) : x;

endmodule

// File: rtl/multu_seq_param.sv
// Iterative shift-add multiplier, one multiplier bit per cycle,
// with optional signed mode and a start/done handshake.
module multu_seq_param
    import mult_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] prod_hi,
    output logic [WIDTH-1:0] prod_lo
);

    localparam int CW = clog2(WIDTH + 1);

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_hi_q;
    logic [WIDTH-1:0] acc_lo_q;
    logic             neg_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] prod_hi_q;
    logic [WIDTH-1:0] prod_lo_q;

    logic [WIDTH-1:0]   a_abs_d;
    logic [WIDTH-1:0]   b_abs_d;
    logic               neg_d;
    logic [2*WIDTH-1:0] fix_d;
    logic [WIDTH:0]     sum_d;
    logic [WIDTH-1:0]   acc_hi_d;
    logic [WIDTH-1:0]   acc_lo_d;

    generate
        if (SIGNED_EN) begin : g_sgn
            logic a_neg;
            logic b_neg;
            assign a_neg = is_signed & a[WIDTH-1];
            assign b_neg = is_signed & b[WIDTH-1];
            assign neg_d = a_neg ^ b_neg;
            twos_negate #(.N(WIDTH)) u_abs_a (
                .cond (a_neg),
                .x    (a),
                .y    (a_abs_d)
            );
            twos_negate #(.N(WIDTH)) u_abs_b (
                .cond (b_neg),
                .x    (b),
                .y    (b_abs_d)
            );
            twos_negate #(.N(2*WIDTH)) u_fix (
                .cond (neg_q),
                .x    ({acc_hi_q, acc_lo_q}),
                .y    (fix_d)
            );
        end else begin : g_uns
            assign a_abs_d = a;
            assign b_abs_d = b;
            assign neg_d   = 1'b0;
            assign fix_d   = {acc_hi_q, acc_lo_q};
        end
    endgenerate

    // The extra carry bit is shifted down into acc_hi each step.
    assign sum_d    = {1'b0, acc_hi_q}
                    + ({1'b0, mcand_q} & {(WIDTH+1){mplier_q[0]}});
    assign acc_hi_d = sum_d[WIDTH:1];
    assign acc_lo_d = {sum_d[0], acc_lo_q[WIDTH-1:1]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            neg_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            prod_hi_q <= '0;
            prod_lo_q <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state_q <= ST_IDLE;
                    if (start) begin
                        state_q  <= ST_RUN;
                        busy_q   <= 1'b1;
                        cnt_q    <= '0;
                        mcand_q  <= a_abs_d;
                        mplier_q <= b_abs_d;
                        neg_q    <= neg_d;
                        acc_hi_q <= '0;
                        acc_lo_q <= '0;
                    end
                end
                ST_RUN: begin
                    if (cnt_q == CW'(WIDTH)) begin
                        state_q <= ST_FIX;
                    end else begin
                        acc_hi_q <= acc_hi_d;
                        acc_lo_q <= acc_lo_d;
                        mplier_q <= mplier_q >> 1;
                        cnt_q    <= cnt_q + CW'(1);
                    end
                end
                ST_FIX: begin
                    prod_hi_q <= fix_d[2*WIDTH-1:WIDTH];
                    prod_lo_q <= fix_d[WIDTH-1:0];
                    busy_q    <= 1'b0;
                    done_q    <= 1'b1;
                    state_q   <= ST_DONE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign prod_hi = prod_hi_q;
    assign prod_lo = prod_lo_q;

endmodule

// File: tb/tb_multu_seq_param.sv
// Scoreboard bench for multu_seq_param: products, latency,
// handshake corner cases, async reset abort, and an 8-bit instance.
module tb_multu_seq_param;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        is_signed;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] prod_hi;
    logic [31:0] prod_lo;

    logic        start8;
    logic        sg8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        busy8;
    logic        done8;
    logic [7:0]  hi8;
    logic [7:0]  lo8;

    typedef struct {
        logic [63:0] p;
        int          e0;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   n_checks;
    int   n_errors;

    multu_seq_param #(.WIDTH(32), .SIGNED_EN(1'b1)) dut (
        .clk       (clk),
        .reset     (rst_n),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .prod_hi   (prod_hi),
        .prod_lo   (prod_lo)
    );

    multu_seq_param #(.WIDTH(8), .SIGNED_EN(1'b1)) dut8 (
        .clk       (clk),
        .reset     (rst_n),
        .start     (start8),
        .is_signed (sg8),
        .a         (a8),
        .b         (b8),
        .busy      (busy8),
        .done      (done8),
        .prod_hi   (hi8),
        .prod_lo   (lo8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] x,
                                          input logic [31:0] y,
                                          input logic sg);
        logic signed [63:0] sx;
        logic signed [63:0] sy;
        if (sg) begin
            sx = {{32{x[31]}}, x};
            sy = {{32{y[31]}}, y};
            return 64'(sx * sy);
        end
        return {32'b0, x} * {32'b0, y};
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            check("done_busy", {63'b0, busy}, 64'd0);
            if (sb.size() == 0) begin
                check("spurious_done", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("prod", {prod_hi, prod_lo}, e.p);
                check("latency", 64'(cyc - e.e0), 64'd34);
            end
        end
    end

    task automatic issue(input logic [31:0] ia, input logic [31:0] ib,
                         input logic sg);
        exp_t e;
        @(negedge clk);
        a         = ia;
        b         = ib;
        is_signed = sg;
        start     = 1'b1;
        e.p  = model(ia, ib, sg);
        e.e0 = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        check("drain", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        exp_t e;
        int   e0a;
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        is_signed = 1'b0;
        a         = '0;
        b         = '0;
        start8    = 1'b0;
        sg8       = 1'b0;
        a8        = '0;
        b8        = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_done", {63'b0, done}, 64'd0);
        check("rst_prod", {prod_hi, prod_lo}, 64'd0);
        check("rst_busy8", {63'b0, busy8}, 64'd0);
        rst_n = 1'b1;

        // 8-bit instance: signed extreme and -1*-1
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            a8     = (k == 0) ? 8'h80 : 8'hFF;
            b8     = a8;
            sg8    = 1'b1;
            start8 = 1'b1;
            e0a    = cyc + 1;
            @(negedge clk);
            start8 = 1'b0;
            for (int i = 0; i < 40; i++) begin
                if (done8) break;
                @(negedge clk);
            end
            check("w8_lat", 64'(cyc - e0a), 64'd10);
            check("w8_prod", {48'b0, hi8, lo8},
                  (k == 0) ? 64'h4000 : 64'h0001);
        end

        issue(32'h17, 32'h3, 1'b0);
        drain();
        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        drain();
        issue(32'hFFFFFFFD, 32'h5, 1'b1);
        drain();
        issue(32'hFFFFFFFD, 32'h5, 1'b0);
        drain();
        issue(32'h80000000, 32'h80000000, 1'b1);
        drain();
        issue(32'h80000000, 32'h7FFFFFFF, 1'b1);
        drain();
        for (int i = 0; i < 6; i++) begin
            issue($urandom, $urandom, i[0]);
            drain();
        end

        // start while running must be ignored
        issue(32'h3, 32'h69, 1'b0);
        repeat (5) @(negedge clk);
        check("busy_run", {63'b0, busy}, 64'd1);
        a     = 32'h7;
        b     = 32'h7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (3) @(negedge clk);
        check("idle_busy", {63'b0, busy}, 64'd0);

        // back-to-back: second start during the done cycle
        issue(32'h12345678, 32'h9ABCDEF0, 1'b0);
        e0a = cyc;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) break;
        end
        a         = 32'h3;
        b         = 32'h69;
        is_signed = 1'b0;
        start     = 1'b1;
        e.p  = 64'h13B;
        e.e0 = cyc + 1;
        sb.push_back(e);
        check("b2b_gap", 64'(e.e0 - e0a), 64'd35);
        @(negedge clk);
        start = 1'b0;
        drain();

        // async reset mid-run aborts
        issue(32'h3, 32'h69, 1'b0);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", {63'b0, busy}, 64'd0);
        check("abort_prod", {prod_hi, prod_lo}, 64'd0);
        sb.delete();
        repeat (3) @(negedge clk);
        check("abort_done", {63'b0, done}, 64'd0);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("abort_nodone", {63'b0, done}, 64'd0);
        issue(32'h3, 32'h69, 1'b0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
